// File: rtl/ps2_scancode_decoder_pkg.sv
// ps2_scancode_decoder_pkg: shared scancode constants, FSM encoding and event layout
package ps2_scancode_decoder_pkg;
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_FE = 8'hFE;
  localparam logic [7:0] SC_EE = 8'hEE;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL = 8'h14;
  localparam logic [7:0] SC_ALT = 8'h11;
  localparam logic [7:0] SC_CAPS = 8'h58;
  localparam logic [7:0] SC_PAUSE = 8'h77;
  localparam int EV_W = 10;
  typedef enum logic [2:0] {S_IDLE, S_GOT_E0, S_GOT_F0, S_GOT_E0F0, S_PAUSE} state_t;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;
  function automatic logic is_response(input logic [7:0] b);
    return b inside {SC_AA, SC_FA, SC_FE, SC_EE, 8'h00, 8'hFF};
  endfunction
endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: valid/ready key-event stream toward the keyboard mapper
interface ps2_scancode_decoder_if;
  logic       event_valid;
  logic       event_ready;
  logic [7:0] event_code;
  logic       event_extended;
  logic       event_break;
  modport master (output event_valid, event_code, event_extended, event_break, input event_ready);
  modport slave (input event_valid, event_code, event_extended, event_break, output event_ready);
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous first-word fall-through FIFO that drops pushes when full
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (AW+1)'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    overflow = push && full && !do_pop;
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout = empty ? '0 : mem_q[rd_q];
  end
  // storage and pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: set-2 byte stream to buffered key events with modifier tracking
module ps2_scancode_decoder
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rx_done_tick,
  input  logic [7:0]                     rx_data,
  ps2_scancode_decoder_if.master         ev,
  output logic                           mod_shift,
  output logic                           mod_ctrl,
  output logic                           mod_alt,
  output logic                           caps_lock,
  output logic                           overflow
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state_q, state_d;
  logic [2:0] pause_q, pause_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [5:0] held_q, held_d, hit;
  logic caps_q, caps_d, caps_held_q, caps_held_d;
  logic emit, as_idle, fake, tmo_end;
  ps2_event_t ev_d, head;
  logic full, empty;
  // prefix FSM: decides whether and how the current byte becomes an event
  always_comb begin
    state_d = state_q;
    pause_d = pause_q;
    emit = 1'b0;
    ev_d = '{ext: 1'b0, brk: 1'b0, code: rx_data};
    fake = rx_data == SC_LSHIFT || rx_data == SC_RSHIFT;
    as_idle = state_q == S_IDLE ||
              (state_q == S_GOT_F0 && (rx_data == SC_E0 || rx_data == SC_E1 || rx_data == SC_F0));
    tmo_end = tmo_q == TW'(TIMEOUT_CYCLES - 1);
    if (rx_done_tick && as_idle) begin
      state_d = rx_data == SC_E0 ? S_GOT_E0 : rx_data == SC_F0 ? S_GOT_F0 :
                rx_data == SC_E1 ? S_PAUSE : S_IDLE;
      pause_d = rx_data == SC_E1 ? 3'd7 : pause_q;
      emit = !(rx_data inside {SC_E0, SC_F0, SC_E1}) && !is_response(rx_data);
    end else if (rx_done_tick) begin
      case (state_q)
        S_GOT_E0: begin
          state_d = rx_data == SC_F0 ? S_GOT_E0F0 : rx_data == SC_E0 ? S_GOT_E0 : S_IDLE;
          emit = !(rx_data == SC_F0 || rx_data == SC_E0 || fake);
          ev_d.ext = 1'b1;
        end
        S_GOT_F0: begin
          state_d = S_IDLE;
          emit = 1'b1;
          ev_d.brk = 1'b1;
        end
        S_GOT_E0F0: begin
          state_d = S_IDLE;
          emit = !fake;
          ev_d.ext = 1'b1;
          ev_d.brk = 1'b1;
        end
        default: begin
          pause_d = pause_q - 3'd1;
          emit = pause_q == 3'd1;
          ev_d = '{ext: 1'b1, brk: 1'b0, code: SC_PAUSE};
          state_d = pause_q == 3'd1 ? S_IDLE : S_PAUSE;
        end
      endcase
    end else if (state_q != S_IDLE && tmo_end) begin
      state_d = S_IDLE;
    end
    tmo_d = (rx_done_tick || state_q == S_IDLE || tmo_end) ? '0 : tmo_q + TW'(1);
  end
  // modifier and Caps Lock tracking on every emitted event, accepted or not
  always_comb begin
    hit = {ev_d.code == SC_ALT && ev_d.ext, ev_d.code == SC_ALT && !ev_d.ext,
           ev_d.code == SC_CTRL && ev_d.ext, ev_d.code == SC_CTRL && !ev_d.ext,
           ev_d.code == SC_RSHIFT && !ev_d.ext, ev_d.code == SC_LSHIFT && !ev_d.ext};
    held_d = !emit ? held_q : ev_d.brk ? held_q & ~hit : held_q | hit;
    caps_d = caps_q ^ (emit && ev_d.code == SC_CAPS && !ev_d.ext && !ev_d.brk && !caps_held_q);
    caps_held_d = (emit && ev_d.code == SC_CAPS && !ev_d.ext) ? !ev_d.brk : caps_held_q;
  end
  // decoder state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pause_q <= '0;
      tmo_q <= '0;
      held_q <= '0;
      caps_q <= 1'b0;
      caps_held_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pause_q <= pause_d;
      tmo_q <= tmo_d;
      held_q <= held_d;
      caps_q <= caps_d;
      caps_held_q <= caps_held_d;
    end
  end
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EV_W)) u_fifo (
    .clk(clk), .reset(reset), .push(emit), .din(ev_d), .pop(ev.event_ready),
    .dout(head), .full(full), .empty(empty), .overflow(overflow)
  );
  assign ev.event_valid = !empty;
  assign ev.event_code = head.code;
  assign ev.event_extended = head.ext;
  assign ev.event_break = head.brk;
  assign mod_shift = |held_q[1:0];
  assign mod_ctrl = |held_q[3:2];
  assign mod_alt = |held_q[5:4];
  assign caps_lock = caps_q;
  logic unused;
  assign unused = full;
endmodule
